hist_frame_ctrl: RTL and testbench

HIST_FRAME_CTRL -- requirements
Module: hist_frame_ctrl

---
 rtl/hist_pkg.sv | 18 +
 rtl/bin_decoder.sv | 25 ++
 rtl/hist_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_hist_frame_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared types and sizes for the histogram frame controller.
package hist_pkg;

  localparam int NUM_BINS  = 256;
  localparam int BIN_W     = 8;
  localparam int PIX_CNT_W = 15;
  localparam int MASS_W    = 9;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    SETTLE,
    SCAN,
    REPORT,
    FLUSH
  } stateT;

endpackage

// File: rtl/bin_decoder.sv
// Registered 8-to-256 one-hot decoder driving the bin counter increments.
module bin_decoder
  import hist_pkg::*;
(
  input  logic                clk,
  input  logic                clear,
  input  logic                en,
  input  logic [BIN_W-1:0]    idx,
  output logic [NUM_BINS-1:0] oneHot
);

  localparam logic [NUM_BINS-1:0] BIT0 = {{(NUM_BINS-1){1'b0}}, 1'b1};

  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      oneHot <= '0;
    end else if (en) begin
      oneHot <= BIT0 << idx;
    end else begin
      oneHot <= '0;
    end
  end

endmodule

// File: rtl/hist_frame_ctrl.sv
// Frame controller: accumulates FRAME_PIXELS pixels into bin counters, then scans
// the CDF comparator flags and reports their count. Optional: HIST_FRAME_CTRL_EXTENT_EN.
module hist_frame_ctrl
  import hist_pkg::*;
#(
  parameter int FRAME_PIXELS = 16384
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                start,
  input  logic                pix_valid,
  input  logic [BIN_W-1:0]    pix_data,
  output logic                pix_ready,
  output logic [NUM_BINS-1:0] bin_inc,
  output logic                cnt_clear,
  input  logic [NUM_BINS-1:0] cdf_flags,
  output logic                busy,
  output logic [MASS_W-1:0]   mass_count,
  output logic                mass_valid
`ifdef HIST_FRAME_CTRL_EXTENT_EN
  ,
  output logic [BIN_W-1:0]    lo_bin,
  output logic [BIN_W-1:0]    hi_bin
`endif
);

  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(FRAME_PIXELS - 1);

  stateT                state;
  logic [PIX_CNT_W-1:0] pixCount;
  logic                 settleCnt;
  logic [BIN_W-1:0]     scanIdx;
  logic [MASS_W-1:0]    massAcc;
  logic [MASS_W-1:0]    massNext;
  logic                 flagNow;
  logic                 accept;

  assign pix_ready = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign accept    = pix_valid & pix_ready;
  // Reset must also wipe the external bin counters, so it bypasses the FSM.
  assign cnt_clear = clear | (state == FLUSH);

`ifdef HIST_FRAME_CTRL_EXTENT_EN
  logic             scanAny;
  logic [BIN_W-1:0] scanLo;
  logic [BIN_W-1:0] scanHi;
  logic             anyNext;
  logic [BIN_W-1:0] loNext;
  logic [BIN_W-1:0] hiNext;
`endif

  // NOTE: every signal written here gets a value first, so no latch is inferred.
  always_comb begin
    flagNow  = cdf_flags[scanIdx];
    massNext = massAcc + MASS_W'(flagNow);
`ifdef HIST_FRAME_CTRL_EXTENT_EN
    anyNext  = scanAny | flagNow;
    loNext   = scanAny ? scanLo : (flagNow ? scanIdx : '0);
    hiNext   = flagNow ? scanIdx : scanHi;
`endif
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      pixCount   <= '0;
      settleCnt  <= 1'b0;
      scanIdx    <= '0;
      massAcc    <= '0;
      mass_count <= '0;
      mass_valid <= 1'b0;
`ifdef HIST_FRAME_CTRL_EXTENT_EN
      scanAny    <= 1'b0;
      scanLo     <= '0;
      scanHi     <= '0;
      lo_bin     <= '0;
      hi_bin     <= '0;
`endif
    end else begin
      mass_valid <= 1'b0;
      unique case (state)
        IDLE: if (start) state <= ACCUM;
        ACCUM: begin
          if (accept) begin
            pixCount <= pixCount + 1'b1;
            if (pixCount == LAST_PIX) begin
              state     <= SETTLE;
              settleCnt <= 1'b0;
            end
          end
        end
        SETTLE: begin
          // First cycle lands the last increment, second lets the comparators settle.
          settleCnt <= 1'b1;
          if (settleCnt) begin
            state   <= SCAN;
            scanIdx <= '0;
            massAcc <= '0;
          end
        end
        SCAN: begin
          massAcc <= massNext;
          scanIdx <= scanIdx + 1'b1;
`ifdef HIST_FRAME_CTRL_EXTENT_EN
          scanAny <= anyNext;
          scanLo  <= loNext;
          scanHi  <= hiNext;
`endif
          // Result is loaded on the last scan edge so it is valid during REPORT.
          if (scanIdx == {BIN_W{1'b1}}) begin
            mass_count <= massNext;
            mass_valid <= 1'b1;
`ifdef HIST_FRAME_CTRL_EXTENT_EN
            lo_bin     <= loNext;
            hi_bin     <= hiNext;
`endif
            state      <= REPORT;
          end
        end
        REPORT: state <= FLUSH;
        FLUSH: begin
          pixCount <= '0;
          massAcc  <= '0;
          scanIdx  <= '0;
`ifdef HIST_FRAME_CTRL_EXTENT_EN
          scanAny  <= 1'b0;
          scanLo   <= '0;
          scanHi   <= '0;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  bin_decoder u_decoder (
    .clk    (clk),
    .clear  (clear),
    .en     (accept),
    .idx    (pix_data),
    .oneHot (bin_inc)
  );

endmodule

// File: tb/tb_hist_frame_ctrl.sv
// Directed self-checking bench for hist_frame_ctrl (FRAME_PIXELS=4 and =1 instances).
module tb_hist_frame_ctrl;
  import hist_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                clear, start, pixValid, pixReady, cntClear, busy, massValid;
  logic [BIN_W-1:0]    pixData;
  logic [NUM_BINS-1:0] binInc, cdfFlags;
  logic [MASS_W-1:0]   massCount;

  logic                start1, pixValid1, pixReady1, cntClear1, busy1, massValid1;
  logic [BIN_W-1:0]    pixData1;
  logic [NUM_BINS-1:0] binInc1, cdfFlags1;
  logic [MASS_W-1:0]   massCount1;

`ifdef HIST_FRAME_CTRL_EXTENT_EN
  logic [BIN_W-1:0] loBin, hiBin, loBin1, hiBin1;
`endif

  int checks   = 0;
  int failures = 0;

  logic [BIN_W-1:0] pixTab [4] = '{8'd3, 8'd3, 8'd7, 8'd255};

  hist_frame_ctrl #(.FRAME_PIXELS(4)) u_dut (
    .clk(clk), .clear(clear), .start(start), .pix_valid(pixValid), .pix_data(pixData),
    .pix_ready(pixReady), .bin_inc(binInc), .cnt_clear(cntClear), .cdf_flags(cdfFlags),
    .busy(busy), .mass_count(massCount), .mass_valid(massValid)
`ifdef HIST_FRAME_CTRL_EXTENT_EN
    , .lo_bin(loBin), .hi_bin(hiBin)
`endif
  );

  hist_frame_ctrl #(.FRAME_PIXELS(1)) u_dut1 (
    .clk(clk), .clear(clear), .start(start1), .pix_valid(pixValid1), .pix_data(pixData1),
    .pix_ready(pixReady1), .bin_inc(binInc1), .cnt_clear(cntClear1), .cdf_flags(cdfFlags1),
    .busy(busy1), .mass_count(massCount1), .mass_valid(massValid1)
`ifdef HIST_FRAME_CTRL_EXTENT_EN
    , .lo_bin(loBin1), .hi_bin(hiBin1)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_BINS-1:0] oneHot(input logic [BIN_W-1:0] i);
    logic [NUM_BINS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // One FRAME_PIXELS=4 frame with pixTab; optional 50% valid gaps, start during SCAN,
  // start together with the last pixel.
  task automatic runFrame(input string tag, input logic [NUM_BINS-1:0] flags,
                          input int expMass, input bit gaps, input bit scanStart,
                          input bit startAtLast);
    int acc, k, pulses, extra, lat, mvCount;
    cdfFlags = flags;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_ready"}, pixReady, 1);
    acc = 0; k = 0; pulses = 0;
    while (acc < 4 && k < 40) begin
      pixValid = !gaps || !k[0];
      pixData  = pixTab[acc];
      start    = startAtLast && (acc == 3) && pixValid;
      tick();
      start = 1'b0;
      if (binInc != '0) pulses++;
      if (pixValid) begin
        check({tag, "_bininc"}, binInc, oneHot(pixTab[acc]));
        acc++;
      end else begin
        check({tag, "_gap"}, binInc, '0);
      end
      k++;
    end
    check({tag, "_pulses"}, pulses, 4);
    check({tag, "_ready_low"}, pixReady, 0);
    // Offered pixels after the frame is full must be ignored.
    pixValid = 1'b1;
    pixData  = 8'd99;
    extra = 0; lat = -1;
    for (int i = 1; i <= 300; i++) begin
      start = scanStart && (i == 100);
      tick();
      if (binInc != '0) extra++;
      if (massValid) begin
        lat = i;
        break;
      end
    end
    start    = 1'b0;
    pixValid = 1'b0;
    check({tag, "_extra"}, extra, 0);
    check({tag, "_latency"}, lat, 258);
    check({tag, "_mass"}, massCount, expMass);
    tick();
    check({tag, "_mv_pulse"}, massValid, 0);
    check({tag, "_flush_clr"}, cntClear, 1);
    check({tag, "_flush_busy"}, busy, 1);
    tick();
    check({tag, "_clr_once"}, cntClear, 0);
    check({tag, "_idle"}, busy, 0);
    mvCount = 0;
    repeat (4) begin
      tick();
      if (massValid || busy) mvCount++;
    end
    check({tag, "_quiet"}, mvCount, 0);
    check({tag, "_hold"}, massCount, expMass);
  endtask

  initial begin
    int mv, lat1;
    clear = 1'b1; start = 1'b0; pixValid = 1'b0; pixData = '0; cdfFlags = '0;
    start1 = 1'b0; pixValid1 = 1'b0; pixData1 = '0; cdfFlags1 = '1;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_ready", pixReady, 0);
    check("rst_mv", massValid, 0);
    check("rst_mass", massCount, 0);
    check("rst_bininc", binInc, '0);
    check("rst_cntclr", cntClear, 1);
    clear = 1'b0;
    #1;
    check("cntclr_rel", cntClear, 0);
    pixValid = 1'b1;
    tick();
    check("idle_ignore", binInc, '0);
    pixValid = 1'b0;

    // FRAME_PIXELS=1: a single pixel goes straight to SETTLE.
    start1 = 1'b1;
    tick();
    start1    = 1'b0;
    pixValid1 = 1'b1;
    pixData1  = 8'd42;
    tick();
    pixValid1 = 1'b0;
    check("fp1_bininc", binInc1, oneHot(8'd42));
    check("fp1_ready", pixReady1, 0);
    check("fp1_busy", busy1, 1);
    lat1 = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (massValid1) begin
        lat1 = i;
        break;
      end
    end
    check("fp1_latency", lat1, 258);
    check("fp1_mass", massCount1, 256);

    runFrame("ones", '1, 256, 1'b0, 1'b0, 1'b0);
`ifdef HIST_FRAME_CTRL_EXTENT_EN
    check("ones_lo", loBin, 0);
    check("ones_hi", hiBin, 255);
`endif
    runFrame("zero", '0, 0, 1'b1, 1'b1, 1'b0);
`ifdef HIST_FRAME_CTRL_EXTENT_EN
    check("zero_lo", loBin, 0);
    check("zero_hi", hiBin, 0);
`endif

    // Clear arriving on the second pixel of a frame.
    start = 1'b1;
    tick();
    start    = 1'b0;
    pixValid = 1'b1;
    pixData  = 8'd5;
    tick();
    check("mid_px1", binInc, oneHot(8'd5));
    pixData = 8'd6;
    clear   = 1'b1;
    #1;
    check("mid_cntclr", cntClear, 1);
    tick();
    check("mid_busy", busy, 0);
    check("mid_ready", pixReady, 0);
    check("mid_bininc", binInc, '0);
    clear    = 1'b0;
    pixValid = 1'b0;
    mv = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (massValid) mv++;
    end
    check("mid_no_mv", mv, 0);

    runFrame("two", oneHot(8'd10) | oneHot(8'd200), 2, 1'b0, 1'b0, 1'b1);
`ifdef HIST_FRAME_CTRL_EXTENT_EN
    check("two_lo", loBin, 10);
    check("two_hi", hiBin, 200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
